adder_stream: RTL and testbench

// Pipelined, parametrised successor of the combinational adder: sums A and B with

---
 rtl/adder_stream.sv | 89 ++++++++
 tb/tb_adder_stream.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_stream.sv
// adder_stream: pipelined adder, signed/unsigned with optional saturation,
// valid/ready flow control on both sides and a completed-transfer counter.
module adder_stream #(
  parameter int DATA_WIDTH = 4,
  parameter int LATENCY    = 2,
  parameter bit SIGNED     = 1'b0,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [DATA_WIDTH:0]   X,
  output logic                  SAT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [15:0]           XFER_COUNT
);

  localparam int DW = DATA_WIDTH;
  localparam logic [DW:0] UMAX = {1'b0, {DW{1'b1}}};
  localparam logic [DW:0] SMAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic [DW:0] SMIN = {2'b11, {(DW-1){1'b0}}};

  logic [DW:0]              a_ext;
  logic [DW:0]              b_ext;
  logic [DW:0]              sum;
  logic [DW:0]              x_d;
  logic                     sat_d;
  logic [LATENCY-1:0]       vld_q;
  logic [LATENCY-1:0]       sat_q;
  logic [LATENCY-1:0][DW:0] x_q;
  logic [15:0]              cnt_q;
  logic [15:0]              cnt_d;
  logic                     stall;
  logic                     xfer;

  // One extra bit holds the exact sum in both signed and unsigned modes.
  always_comb begin
    a_ext = SIGNED ? {A[DW-1], A} : {1'b0, A};
    b_ext = SIGNED ? {B[DW-1], B} : {1'b0, B};
    sum   = a_ext + b_ext;
    x_d   = sum;
    sat_d = 1'b0;
    if (SATURATE) begin
      if (!SIGNED && sum[DW]) begin
        x_d   = UMAX;
        sat_d = 1'b1;
      end else if (SIGNED && (sum[DW] != sum[DW-1])) begin
        x_d   = sum[DW] ? SMIN : SMAX;
        sat_d = 1'b1;
      end
    end
  end

  assign stall      = vld_q[LATENCY-1] & ~OUT_READY;
  assign xfer       = vld_q[LATENCY-1] & OUT_READY;
  assign IN_READY   = RST_N & ~stall;
  assign cnt_d      = xfer ? cnt_q + 16'd1 : cnt_q;
  assign X          = x_q[LATENCY-1];
  assign SAT        = sat_q[LATENCY-1];
  assign OUT_VALID  = vld_q[LATENCY-1];
  assign XFER_COUNT = cnt_q;

  // Whole pipe advances together; bubbles move rather than collapse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      sat_q <= '0;
      x_q   <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) begin
        vld_q[0] <= IN_VALID;
        sat_q[0] <= sat_d;
        x_q[0]   <= x_d;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          sat_q[i] <= sat_q[i-1];
          x_q[i]   <= x_q[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_stream.sv
// tb_adder_stream: four LATENCY=2 variants plus one LATENCY=4 unsigned
// instance, checked against an integer reference model and scoreboards.
module tb_adder_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] a2 = '0, b2 = '0, a4 = '0, b4 = '0;
  logic iv2 = 1'b0, or2 = 1'b1, iv4 = 1'b0, or4 = 1'b1;

  logic [4:0] ov, ir, sat;
  logic [4:0][4:0] x;
  logic [4:0][15:0] cnt;

  logic [5:0] got [5][$];
  logic [5:0] expq [4][$];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_l2
    adder_stream #(
      .DATA_WIDTH(4), .LATENCY(2),
      .SIGNED((g % 2) == 1), .SATURATE(g >= 2)
    ) dut (
      .CLK(clk), .RST_N(rst_n),
      .A(a2), .B(b2),
      .IN_VALID(iv2), .IN_READY(ir[g]),
      .X(x[g]), .SAT(sat[g]),
      .OUT_VALID(ov[g]), .OUT_READY(or2),
      .XFER_COUNT(cnt[g])
    );
  end

  adder_stream #(
    .DATA_WIDTH(4), .LATENCY(4),
    .SIGNED(1'b0), .SATURATE(1'b0)
  ) u4 (
    .CLK(clk), .RST_N(rst_n),
    .A(a4), .B(b4),
    .IN_VALID(iv4), .IN_READY(ir[4]),
    .X(x[4]), .SAT(sat[4]),
    .OUT_VALID(ov[4]), .OUT_READY(or4),
    .XFER_COUNT(cnt[4])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++)
      if (ov[i] && ((i < 4) ? or2 : or4))
        got[i].push_back({sat[i], x[i]});
  end

  function automatic logic [5:0] ref_sum(int a, int b, bit sgn, bit sat_m);
    int va, vb, s, lo, hi;
    bit c;
    logic [31:0] sv;
    va = (sgn && a >= 8) ? a - 16 : a;
    vb = (sgn && b >= 8) ? b - 16 : b;
    s  = va + vb;
    c  = 1'b0;
    if (sat_m) begin
      lo = sgn ? -8 : 0;
      hi = sgn ? 7 : 15;
      if (s > hi) begin s = hi; c = 1'b1; end
      else if (s < lo) begin s = lo; c = 1'b1; end
    end
    sv = s;
    return {c, sv[4:0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    iv2 = 1'b0; iv4 = 1'b0;
    or2 = 1'b1; or4 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) got[i].delete();
  endtask

  task automatic drive_beat(input logic [3:0] a, input logic [3:0] b);
    a2 = a; b2 = b; iv2 = 1'b1;
    @(posedge clk);
    #1 iv2 = 1'b0;
  endtask

  task automatic test_reset();
    iv2 = 1'b1; iv4 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({ir[i], ov[i], sat[i], x[i], cnt[i]} !== '0) begin
        bad++;
        $display("FAIL reset_state inst=%0d ir=%b ov=%b sat=%b x=%0d cnt=%0d want all 0",
                 i, ir[i], ov[i], sat[i], x[i], cnt[i]);
      end
    end
    iv2 = 1'b0; iv4 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ir[i] !== 1'b1) begin
        bad++;
        $display("FAIL ready_after_reset inst=%0d got=%b want=1", i, ir[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [5:0] e;
    do_reset();
    e = ref_sum(9, 8, 1'b0, 1'b0);
    a2 = 4'd9; b2 = 4'd8; iv2 = 1'b1; or2 = 1'b1;
    @(negedge clk);
    total++;
    if (ir[0] !== 1'b1) begin
      bad++; $display("FAIL unsigned_ready got=%b want=1", ir[0]);
    end
    @(posedge clk);
    #1 iv2 = 1'b0;
    @(negedge clk);
    total++;
    if (ov[0] !== 1'b0) begin
      bad++; $display("FAIL unsigned_early got=%b want=0", ov[0]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (ov[0] !== 1'b1 || x[0] !== 5'b10001 || sat[0] !== 1'b0) begin
      bad++;
      $display("FAIL unsigned_result ov=%b x=%0d sat=%b want ov=1 x=17 sat=0",
               ov[0], x[0], sat[0]);
    end
    total++;
    if ({sat[0], x[0]} !== e) begin
      bad++; $display("FAIL unsigned_model got=%h want=%h", {sat[0], x[0]}, e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (ov[0] !== 1'b0 || cnt[0] !== 16'd1) begin
      bad++; $display("FAIL unsigned_count ov=%b cnt=%0d want ov=0 cnt=1", ov[0], cnt[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int sent, nout;
    sent = 0; nout = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      iv2 = (sent < 4);
      a2 = 4'(sent + 1); b2 = 4'(sent + 1);
      or2 = !(c >= 3 && c < 6);
      @(negedge clk);
      if (ov[0]) begin
        total++;
        if (x[0] !== 5'(2 * (nout + 1))) begin
          bad++; $display("FAIL bp_order x=%0d want=%0d", x[0], 2 * (nout + 1));
        end
        if (or2) nout++;
      end
      total++;
      if (ov[0] && !or2) begin
        if (ir[0] !== 1'b0) begin
          bad++; $display("FAIL bp_ready_stall got=%b want=0 cyc=%0d", ir[0], c);
        end
      end else if (ir[0] !== 1'b1) begin
        bad++; $display("FAIL bp_ready_free got=%b want=1 cyc=%0d", ir[0], c);
      end
      if (iv2 && ir[0]) sent++;
      @(posedge clk); #1;
    end
    iv2 = 1'b0; or2 = 1'b1;
    total++;
    if (nout != 4 || cnt[0] !== 16'd4) begin
      bad++; $display("FAIL bp_count outputs=%0d cnt=%0d want 4/4", nout, cnt[0]);
    end
  endtask

  task automatic test_signed();
    do_reset();
    drive_beat(4'b1000, 4'b1111);
    drive_beat(4'd7, 4'd7);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (got[1].size() != 2) begin
      bad++; $display("FAIL signed_count got=%0d want=2", got[1].size());
    end else begin
      total++;
      if (got[1][0] !== {1'b0, 5'b10111} || got[1][1] !== {1'b0, 5'd14}) begin
        bad++;
        $display("FAIL signed_values got=%h,%h want=17,0e", got[1][0], got[1][1]);
      end
    end
  endtask

  task automatic test_saturate();
    int ba [4] = '{15, 7, 8, 3};
    int bb [4] = '{15, 7, 8, 2};
    do_reset();
    for (int k = 0; k < 4; k++) drive_beat(4'(ba[k]), 4'(bb[k]));
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i].size() != 4) begin
        bad++; $display("FAIL sat_count inst=%0d got=%0d want=4", i, got[i].size());
      end
    end
    if (got[2].size() == 4 && got[3].size() == 4) begin
      total++;
      if (got[2][0] !== {1'b1, 5'd15}) begin
        bad++; $display("FAIL sat_u15 got=%h want=2f", got[2][0]);
      end
      total++;
      if (got[3][1] !== {1'b1, 5'd7} || got[3][2] !== {1'b1, 5'b11000} ||
          got[3][3] !== {1'b0, 5'd5}) begin
        bad++;
        $display("FAIL sat_signed got=%h,%h,%h want=27,38,05",
                 got[3][1], got[3][2], got[3][3]);
      end
    end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < got[i].size() && k < 4; k++) begin
        total++;
        if (got[i][k] !== ref_sum(ba[k], bb[k], (i % 2) == 1, i >= 2)) begin
          bad++;
          $display("FAIL sat_model inst=%0d beat=%0d got=%h want=%h", i, k,
                   got[i][k], ref_sum(ba[k], bb[k], (i % 2) == 1, i >= 2));
        end
      end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive_beat(4'd9, 4'd9);
    repeat (2) @(posedge clk);
    #1 or2 = 1'b0;
    drive_beat(4'd1, 4'd2);
    drive_beat(4'd3, 4'd4);
    total++;
    if (ov[0] !== 1'b1 || cnt[0] !== 16'd1) begin
      bad++; $display("FAIL mid_pre ov=%b cnt=%0d want ov=1 cnt=1", ov[0], cnt[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ov[i] !== 1'b0 || cnt[i] !== 16'd0 || ir[i] !== 1'b0) begin
        bad++;
        $display("FAIL mid_async inst=%0d ov=%b cnt=%0d ir=%b want 0/0/0",
                 i, ov[i], cnt[i], ir[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    or2 = 1'b1;
    for (int i = 0; i < 5; i++) got[i].delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ov[0] !== 1'b0) begin
        bad++; $display("FAIL mid_stale cyc=%0d ov=%b want=0", c, ov[0]);
      end
    end
    @(posedge clk); #1;
    drive_beat(4'd5, 4'd6);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (got[0].size() != 1 || cnt[0] !== 16'd1) begin
      bad++;
      $display("FAIL mid_after results=%0d cnt=%0d want 1/1", got[0].size(), cnt[0]);
    end else begin
      total++;
      if (got[0][0] !== {1'b0, 5'd11}) begin
        bad++; $display("FAIL mid_value got=%h want=0b", got[0][0]);
      end
    end
  endtask

  task automatic test_random();
    int bad_k;
    do_reset();
    for (int i = 0; i < 4; i++) expq[i].delete();
    for (int c = 0; c < 400; c++) begin
      iv2 = ($urandom % 4) != 0;
      a2 = 4'($urandom); b2 = 4'($urandom);
      or2 = ($urandom % 3) != 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ir[i] !== !(ov[i] && !or2)) begin
          bad++;
          $display("FAIL rand_ready inst=%0d cyc=%0d got=%b ov=%b or=%b",
                   i, c, ir[i], ov[i], or2);
        end
        if (iv2 && ir[i])
          expq[i].push_back(ref_sum(int'(a2), int'(b2), (i % 2) == 1, i >= 2));
      end
      @(posedge clk); #1;
    end
    iv2 = 1'b0; or2 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got[i].size() != expq[i].size() || cnt[i] !== 16'(expq[i].size())) begin
        bad++;
        $display("FAIL rand_count inst=%0d got=%0d cnt=%0d want=%0d",
                 i, got[i].size(), cnt[i], expq[i].size());
      end
      bad_k = -1;
      for (int k = 0; k < got[i].size() && k < expq[i].size(); k++)
        if (got[i][k] !== expq[i][k] && bad_k < 0) bad_k = k;
      total++;
      if (bad_k >= 0) begin
        bad++;
        $display("FAIL rand_data inst=%0d idx=%0d got=%h want=%h",
                 i, bad_k, got[i][bad_k], expq[i][bad_k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ba [16];
    int bb [16];
    bit want;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      ba[k] = $urandom_range(0, 15);
      bb[k] = $urandom_range(0, 15);
    end
    for (int c = 0; c < 24; c++) begin
      iv4 = (c < 16);
      if (c < 16) begin a4 = 4'(ba[c]); b4 = 4'(bb[c]); end
      @(negedge clk);
      want = (c >= 4 && c < 20);
      total++;
      if (ov[4] !== want) begin
        bad++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", c, ov[4], want);
      end
      if (want) begin
        total++;
        if ({sat[4], x[4]} !== ref_sum(ba[c-4], bb[c-4], 1'b0, 1'b0)) begin
          bad++;
          $display("FAIL b2b_data cyc=%0d got=%h want=%h", c, {sat[4], x[4]},
                   ref_sum(ba[c-4], bb[c-4], 1'b0, 1'b0));
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (cnt[4] !== 16'd16) begin
      bad++; $display("FAIL b2b_count got=%0d want=16", cnt[4]);
    end
    iv4 = 1'b1; a4 = 4'd3; b4 = 4'd4;
    repeat (65519) @(posedge clk);
    #1 iv4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    got[4].delete();
    total++;
    if (cnt[4] !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_max got=%h want=ffff", cnt[4]);
    end
    iv4 = 1'b1;
    @(posedge clk);
    #1 iv4 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (cnt[4] !== 16'h0000) begin
      bad++; $display("FAIL wrap_zero got=%h want=0000", cnt[4]);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_backpressure();
    test_signed();
    test_saturate();
    test_reset_midstream();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
